// File: rtl/particle_field.sv
// Animated square-particle engine: sequential per-frame update sweep (one particle
// per clock) plus a registered pixel-vs-particle hit test for the colour mux.
module particle_field #(
  parameter int          N_PART = 16,
  parameter int          SIZE   = 10,
  parameter int          CX     = 320,
  parameter int          CY     = 280,
  parameter int          X_MIN  = 150,
  parameter int          X_MAX  = 490,
  parameter int          Y_MIN  = 120,
  parameter int          Y_MAX  = 360,
  parameter int          LIFE   = 64,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       pause,
  input  logic       mode,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       hit,
  output logic [4:0] hit_id,
  output logic       busy,
  output logic       missed
);
  localparam int KW = (N_PART > 1) ? $clog2(N_PART) : 1;
  localparam int AW = (LIFE > 1) ? $clog2(LIFE) : 1;
  localparam logic signed [10:0] XL = 11'(X_MIN);
  localparam logic signed [10:0] XH = 11'(X_MAX - SIZE);
  localparam logic signed [10:0] YL = 11'(Y_MIN);
  localparam logic signed [10:0] YH = 11'(Y_MAX - SIZE);

  typedef enum logic {IDLE, SWEEP} state_t;

  logic [9:0]        x_q   [N_PART];
  logic [9:0]        y_q   [N_PART];
  logic signed [3:0] vx_q  [N_PART];
  logic signed [3:0] vy_q  [N_PART];
  logic [AW-1:0]     age_q [N_PART];
  logic [15:0]       lfsr_q;
  state_t            state_q;
  logic [KW-1:0]     k_q;
  logic              hit_q, busy_q, missed_q;
  logic [4:0]        id_q;

  // Next state of the particle currently addressed by the sweep
  logic signed [10:0] cx, cy, nx, ny;
  logic [9:0]         x_d, y_d;
  logic signed [3:0]  vx_d, vy_d;
  logic [AW-1:0]      age_d;
  logic [15:0]        lfsr_d;
  logic               oxl, oxh, oyl, oyh, respawn;

  always_comb begin
    cx      = {1'b0, x_q[k_q]};
    cy      = {1'b0, y_q[k_q]};
    nx      = cx + {{7{vx_q[k_q][3]}}, vx_q[k_q]};
    ny      = cy + {{7{vy_q[k_q][3]}}, vy_q[k_q]};
    age_d   = age_q[k_q] + 1'b1;
    oxl     = nx < XL;
    oxh     = nx > XH;
    oyl     = ny < YL;
    oyh     = ny > YH;
    respawn = (age_d == '0) || (!mode && (oxl || oxh || oyl || oyh));
    x_d     = nx[9:0];
    y_d     = ny[9:0];
    vx_d    = vx_q[k_q];
    vy_d    = vy_q[k_q];
    lfsr_d  = lfsr_q;
    if (respawn) begin
      x_d    = 10'(CX);
      y_d    = 10'(CY);
      vx_d   = {lfsr_q[2], lfsr_q[2:0]};
      vy_d   = {lfsr_q[5], lfsr_q[5:3]};
      if (lfsr_q[5:0] == 6'd0) vx_d = 4'sd1;
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end else begin
      // Only reachable out of bounds in bounce mode: clamp and reflect per axis
      if (oxl || oxh) begin
        x_d  = oxl ? XL[9:0] : XH[9:0];
        vx_d = -vx_q[k_q];
      end
      if (oyl || oyh) begin
        y_d  = oyl ? YL[9:0] : YH[9:0];
        vy_d = -vy_q[k_q];
      end
    end
  end

  // Hit test against live registers; scanning downward leaves the lowest index
  logic       hit_c;
  logic [4:0] id_c;
  logic [9:0] dx, dy;

  always_comb begin
    hit_c = 1'b0;
    id_c  = '0;
    dx    = '0;
    dy    = '0;
    for (int i = N_PART - 1; i >= 0; i--) begin
      dx = pix_x - x_q[i];
      dy = pix_y - y_q[i];
      if (dx < 10'(SIZE) && dy < 10'(SIZE)) begin
        hit_c = 1'b1;
        id_c  = 5'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_PART; i++) begin
        x_q[i]   <= 10'(CX);
        y_q[i]   <= 10'(CY);
        vx_q[i]  <= 4'sd1;
        vy_q[i]  <= 4'sd0;
        age_q[i] <= AW'(i * (LIFE / N_PART));
      end
      lfsr_q   <= SEED;
      state_q  <= IDLE;
      k_q      <= '0;
      hit_q    <= 1'b0;
      id_q     <= '0;
      busy_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      hit_q <= hit_c;
      id_q  <= id_c;
      case (state_q)
        IDLE: if (frame_start && !pause) begin
          state_q <= SWEEP;
          k_q     <= '0;
          busy_q  <= 1'b1;
        end
        SWEEP: begin
          if (frame_start) missed_q <= 1'b1;
          x_q[k_q]   <= x_d;
          y_q[k_q]   <= y_d;
          vx_q[k_q]  <= vx_d;
          vy_q[k_q]  <= vy_d;
          age_q[k_q] <= age_d;
          lfsr_q     <= lfsr_d;
          if (k_q == KW'(N_PART - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hit    = hit_q;
  assign hit_id = id_q;
  assign busy   = busy_q;
  assign missed = missed_q;
endmodule

// File: tb/tb_particle_field.sv
// Randomized check of particle_field against a frame-level model of the particle
// rules; positions are observed through the registered hit/hit_id outputs.
module tb_particle_field;
  localparam int N = 16, SZ = 10, LIFE = 64;

  logic       clk = 0, reset = 1, frame_start = 0, pause = 0, mode = 0;
  logic [9:0] pix_x = 0, pix_y = 0;
  logic       hit, busy, missed;
  logic [4:0] hit_id;

  particle_field dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pause(pause), .mode(mode),
    .pix_x(pix_x), .pix_y(pix_y), .hit(hit), .hit_id(hit_id), .busy(busy), .missed(missed)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int mx[N], my[N], mvx[N], mvy[N], mage[N];
  int lfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int sext3(input int v);
    return (v >= 4) ? v - 8 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 320; my[i] = 280; mvx[i] = 1; mvy[i] = 0; mage[i] = i * (LIFE / N);
    end
    lfsr = 16'hACE1;
  endtask

  // One frame of the particle rules, particles visited in index order
  task automatic model_frame(input bit m);
    for (int k = 0; k < N; k++) begin
      int nx, ny, a;
      bit ox, oy;
      nx = mx[k] + mvx[k];
      ny = my[k] + mvy[k];
      a  = (mage[k] + 1) % LIFE;
      ox = (nx < 150) || (nx > 480);
      oy = (ny < 120) || (ny > 350);
      mage[k] = a;
      if (a == 0 || (!m && (ox || oy))) begin
        mx[k] = 320; my[k] = 280;
        mvx[k] = sext3(lfsr & 7);
        mvy[k] = sext3((lfsr >> 3) & 7);
        if (mvx[k] == 0 && mvy[k] == 0) mvx[k] = 1;
        lfsr = ((lfsr >> 1) ^ ((lfsr & 1) ? 16'hB400 : 0)) & 16'hFFFF;
      end else begin
        if (ox) begin mx[k] = (nx < 150) ? 150 : 480; mvx[k] = -mvx[k]; end
        else mx[k] = nx;
        if (oy) begin my[k] = (ny < 120) ? 120 : 350; mvy[k] = -mvy[k]; end
        else my[k] = ny;
      end
    end
  endtask

  task automatic probe(input string tag, input int px, input int py);
    int eh, eid;
    eh = 0; eid = 0;
    for (int i = N - 1; i >= 0; i--)
      if (((px - mx[i]) & 1023) < SZ && ((py - my[i]) & 1023) < SZ) begin
        eh = 1; eid = i;
      end
    pix_x = 10'(px); pix_y = 10'(py);
    tick();
    chk({tag, ".hit"}, 32'(hit), 32'(eh));
    chk({tag, ".id"}, 32'(hit_id), 32'(eid));
  endtask

  // Pulse frame_start; optionally re-pulse mid-sweep; measure busy length
  task automatic run_frame(input bit m, input int repulse_at);
    int cnt;
    mode = m;
    frame_start = 1; tick(); frame_start = 0;
    chk("busy_rise", 32'(busy), 32'd1);
    cnt = 0;
    while (busy && cnt < 100) begin
      if (cnt == repulse_at) frame_start = 1;
      tick();
      frame_start = 0;
      cnt++;
    end
    chk("busy_len", 32'(cnt), 32'(N));
    model_frame(m);
  endtask

  task automatic probe_all(input string tag);
    for (int i = 0; i < N; i++)
      probe(tag, mx[i] + $urandom_range(0, SZ - 1), my[i] + $urandom_range(0, SZ - 1));
    probe({tag, ".rnd"}, $urandom_range(140, 500), $urandom_range(110, 370));
  endtask

  initial begin
    int cnt;
    reset = 1; tick(); tick(); reset = 0;
    model_reset();
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_missed", 32'(missed), 32'd0);
    probe("emit", 325, 285);
    chk("emit_const", 32'(hit_id), 32'd0);
    probe("far", 100, 100);

    run_frame(0, -1);
    probe("f1_left", 320, 285);
    probe("f1_right", 330, 280);
    chk("f1_const", 32'(hit), 32'd1);

    // Respawn mode long run, then bounce, then mixed
    for (int f = 1; f < 200; f++) begin
      run_frame(0, -1);
      if (f % 8 == 0 || f == 63) probe_all("m0");
    end
    probe_all("m0_end");
    for (int f = 0; f < 200; f++) begin
      run_frame(1, -1);
      if (f % 8 == 0) probe_all("m1");
    end
    probe_all("m1_end");
    for (int f = 0; f < 100; f++) begin
      run_frame(1'($urandom_range(0, 1)), -1);
      if (f % 4 == 0) probe_all("mix");
    end

    // frame_start during a sweep is dropped and flagged
    chk("missed_pre", 32'(missed), 32'd0);
    run_frame(0, 5);
    repeat (4) begin
      tick();
      chk("no_2nd_sweep", 32'(busy), 32'd0);
    end
    chk("missed_set", 32'(missed), 32'd1);
    probe_all("after_miss");

    // pause gates the start of a sweep
    pause = 1; frame_start = 1; tick(); frame_start = 0;
    chk("pause_busy", 32'(busy), 32'd0);
    tick();
    chk("pause_busy2", 32'(busy), 32'd0);
    pause = 0;
    probe_all("paused");

    // Reset in the middle of a sweep
    frame_start = 1; tick(); frame_start = 0;
    repeat (8) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1; tick(); reset = 0;
    model_reset();
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_missed", 32'(missed), 32'd0);
    chk("mrst_hit", 32'(hit), 32'd0);
    probe("mrst_emit", 325, 285);
    probe("mrst_far", 100, 100);
    cnt = 0;
    for (int f = 0; f < 20; f++) run_frame(1'($urandom_range(0, 1)), -1);
    probe_all("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
